branch_predictor: RTL and testbench

- Fetch-side branch predictor and misprediction recovery unit, directly upstream of Next_PC_Logic.
- Looks up the current fetch PC in a direct-mapped BTB with 2-bit saturating counters. Drives branch_predict/branch_pc into Next_PC_Logic.
- Compares the resolved branch outcome from EX against the carried prediction. On mismatch, drives branch_undo with the correct recovery PC on pc_not_taken.

---
 rtl/branch_predictor.sv | 128 ++++++++++++
 tb/tb_branch_predictor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit counters plus misprediction recovery.
// Optional stat_branches/stat_mispredicts outputs under BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        branch_predict,
  output logic [31:0] branch_pc,
  output logic        branch_undo,
  output logic [31:0] pc_not_taken
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [31:0]      tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  logic        undo_q, undo_d;
  logic [31:0] pnt_q, pnt_d;

  logic [IDX_W-1:0] idx, ex_idx;
  logic [TAG_W-1:0] tag, ex_tag;
  logic             hit, ex_hit, upd, mispredict;
  logic [1:0]       ctr_d;
  logic             ctr_wr, tgt_wr, alloc;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^pc[1:0];

  assign idx    = pc[IDX_W+1:2];
  assign tag    = pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  assign hit    = valid_q[idx] & (tag_q[idx] == tag);
  assign ex_hit = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);

  assign branch_predict = hit & ctr_q[idx][1] & ~stall & ~undo_q;
  assign branch_pc      = hit ? tgt_q[idx] : '0;
  assign branch_undo    = undo_q;
  assign pc_not_taken   = pnt_q;

  // EX resolutions arriving while an undo is in flight are wrong-path and ignored.
  assign upd        = ex_valid & ex_is_branch & ~undo_q;
  assign mispredict = upd & ((ex_pred_taken != ex_taken) |
                             (ex_pred_taken & ex_taken & (ex_pred_target != ex_target)));

  always_comb begin
    ctr_d  = ctr_q[ex_idx];
    ctr_wr = 1'b0;
    tgt_wr = 1'b0;
    alloc  = 1'b0;
    undo_d = mispredict;
    pnt_d  = pnt_q;
    if (mispredict) pnt_d = ex_taken ? ex_target : ex_pc + 32'd4;
    if (upd) begin
      if (ex_hit) begin
        ctr_wr = 1'b1;
        tgt_wr = ex_taken;
        if (ex_taken) ctr_d = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        else          ctr_d = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
      end else if (ex_taken) begin
        alloc  = 1'b1;
        ctr_wr = 1'b1;
        tgt_wr = 1'b1;
        ctr_d  = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      undo_q <= 1'b0;
      pnt_q  <= '0;
    end else begin
      if (ctr_wr) ctr_q[ex_idx] <= ctr_d;
      if (tgt_wr) tgt_q[ex_idx] <= ex_target;
      if (alloc) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
      end
      undo_q <= undo_d;
      pnt_q  <= pnt_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (upd && (br_cnt_q != '1))        br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && (mp_cnt_q != '1)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign stat_branches    = br_cnt_q;
  assign stat_mispredicts = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = 32'h40;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        branch_predict;
  logic [31:0] branch_pc;
  logic        branch_undo;
  logic [31:0] pc_not_taken;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .stall(stall),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .branch_predict(branch_predict), .branch_pc(branch_pc),
    .branch_undo(branch_undo), .pc_not_taken(pc_not_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per table slot, counter kept as an integer 0..3.
  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  bit          m_undo;
  logic [31:0] m_pnt;

  function automatic int unsigned slot(input logic [31:0] a);
    return (a / 4) % 16;
  endfunction

  function automatic int unsigned tagof(input logic [31:0] a);
    return a / 64;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_undo = 0;
    m_pnt  = '0;
  endfunction

  function automatic void mstep();
    int unsigned s;
    bit upd, mis, h;
    s   = slot(ex_pc);
    h   = m_v[s] && (m_tag[s] == tagof(ex_pc));
    upd = ex_valid && ex_is_branch && !m_undo;
    mis = upd && ((ex_pred_taken != ex_taken) ||
                  (ex_pred_taken && ex_taken && ex_pred_target != ex_target));
    if (upd && h) begin
      if (ex_taken) begin
        if (m_ctr[s] < 3) m_ctr[s]++;
        m_tgt[s] = ex_target;
      end else if (m_ctr[s] > 0) m_ctr[s]--;
    end else if (upd && ex_taken) begin
      m_v[s] = 1; m_tag[s] = tagof(ex_pc); m_tgt[s] = ex_target; m_ctr[s] = 2;
    end
    m_undo = mis;
    if (mis) m_pnt = ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  always @(negedge clk) begin
    int unsigned s;
    bit h;
    if (!rst_n) mreset();
    s = slot(pc);
    h = m_v[s] && (m_tag[s] == tagof(pc));
    chk("model_predict", {31'b0, branch_predict}, {31'b0, h && m_ctr[s] >= 2 && !stall && !m_undo});
    chk("model_branch_pc", branch_pc, h ? m_tgt[s] : 32'h0);
    chk("model_undo", {31'b0, branch_undo}, {31'b0, m_undo});
    chk("model_pc_not_taken", pc_not_taken, m_pnt);
    if (rst_n) mstep();
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input logic [31:0] a, input logic tk, input logic [31:0] tg,
                        input logic ptk, input logic [31:0] ptg);
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = a;
    ex_taken = tk; ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    if ($urandom_range(0, 19) == 0) return 32'hFFFF_FFFC;
    r = 32'($urandom_range(0, 3)) * 32'd64 + 32'($urandom_range(0, 15)) * 32'd4
        + 32'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_predict", {31'b0, branch_predict}, 32'h0);
      chk("reset_undo", {31'b0, branch_undo}, 32'h0);
      chk("reset_pnt", pc_not_taken, 32'h0);
      cyc();
    end

    ex_set(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    cyc();
    chk("cold_undo", {31'b0, branch_undo}, 32'h1);
    chk("cold_pnt", pc_not_taken, 32'h100);
    chk("cold_predict_during_undo", {31'b0, branch_predict}, 32'h0);
    ex_valid = 1'b0;
    cyc();
    chk("cold_undo_clear", {31'b0, branch_undo}, 32'h0);
    chk("cold_predict", {31'b0, branch_predict}, 32'h1);
    chk("cold_branch_pc", branch_pc, 32'h100);

    ex_set(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    cyc();
    chk("nt_undo", {31'b0, branch_undo}, 32'h1);
    chk("nt_pnt", pc_not_taken, 32'h44);
    ex_valid = 1'b0;
    cyc();
    chk("nt_predict", {31'b0, branch_predict}, 32'h0);
    chk("nt_branch_pc", branch_pc, 32'h100);

    for (int i = 0; i < 3; i++) begin
      ex_set(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
      cyc();
    end
    ex_set(32'h40, 1'b0, 32'h100, 1'b0, 32'h0);
    cyc();
    ex_valid = 1'b0;
    chk("hyst_undo", {31'b0, branch_undo}, 32'h0);
    chk("hyst_predict", {31'b0, branch_predict}, 32'h1);

    ex_set(32'h80, 1'b1, 32'h200, 1'b1, 32'h200);
    cyc();
    ex_valid = 1'b0;
    #1;
    chk("alias_old_predict", {31'b0, branch_predict}, 32'h0);
    chk("alias_old_branch_pc", branch_pc, 32'h0);
    pc = 32'h80; #1;
    chk("alias_new_predict", {31'b0, branch_predict}, 32'h1);
    chk("alias_new_branch_pc", branch_pc, 32'h200);
    stall = 1'b1; #1;
    chk("stall_predict", {31'b0, branch_predict}, 32'h0);
    stall = 1'b0;
    cyc();

    ex_set(32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10);
    cyc();
    chk("wrap_undo", {31'b0, branch_undo}, 32'h1);
    chk("wrap_pnt", pc_not_taken, 32'h0);
    ex_valid = 1'b0;
    cyc();

    ex_set(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    cyc();
    chk("b2b_first_undo", {31'b0, branch_undo}, 32'h1);
    chk("b2b_first_pnt", pc_not_taken, 32'h300);
    ex_set(32'h80, 1'b0, 32'h300, 1'b1, 32'h300);
    cyc();
    chk("b2b_second_undo", {31'b0, branch_undo}, 32'h0);
    ex_valid = 1'b0;
    #1;
    chk("b2b_predict", {31'b0, branch_predict}, 32'h1);
    chk("b2b_branch_pc", branch_pc, 32'h300);
    cyc();

    ex_set(32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
    cyc();
    chk("rst_pre_undo", {31'b0, branch_undo}, 32'h1);
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_undo", {31'b0, branch_undo}, 32'h0);
    chk("rst_mid_pnt", pc_not_taken, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_after_undo", {31'b0, branch_undo}, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rst_n          = ($urandom_range(0, 299) != 0);
      pc             = rand_pc();
      stall          = ($urandom_range(0, 4) == 0);
      ex_valid       = ($urandom_range(0, 9) < 7);
      ex_is_branch   = ($urandom_range(0, 9) < 8);
      ex_pc          = rand_pc();
      ex_taken       = $urandom_range(0, 1) == 1;
      ex_target      = 32'($urandom_range(1, 4)) * 32'h100;
      ex_pred_taken  = $urandom_range(0, 1) == 1;
      ex_pred_target = ($urandom_range(0, 2) != 0) ? ex_target : 32'($urandom_range(1, 4)) * 32'h100;
      cyc();
    end
    rst_n = 1'b1;
    ex_valid = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
